// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param.
// master drives r/w/din; slave returns dout, occupancy and status flags.
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             r;
    logic             w;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             is_empty;
    logic             is_full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output r, w, din,
        input  dout, is_empty, is_full,
        input  almost_empty, almost_full,
        input  count, overflow, underflow
    );

    modport slave (
        input  r, w, din,
        output dout, is_empty, is_full,
        output almost_empty, almost_full,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with count, thresholds, error pulses, FWFT.
// Ports: clk, reset (async active-low), bus (slave: r/w/din in, data+flags out).
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                clk,
    input  logic                reset,
    sync_fifo_param_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dout_q;
    logic             ovf_q;
    logic             unf_q;
    logic             empty;
    logic             full;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);

    // A pop at full frees the slot the simultaneous push needs.
    assign rd_ok = bus.r & ~empty;
    assign wr_ok = bus.w & (~full | rd_ok);

    // Storage holds no reset; emptiness is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            ovf_q <= bus.w & ~wr_ok;
            unf_q <= bus.r & ~rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout_q <= mem[rd_ptr];
            end
            unique case (1'b1)
                wr_ok && !rd_ok: cnt <= cnt + CW'(1);
                rd_ok && !wr_ok: cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // FWFT shows the head directly; forced to 0 while empty so that
    // reset drives dout low in both modes.
    assign bus.dout = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr])
                                  : dout_q;

    assign bus.is_empty     = empty;
    assign bus.is_full      = full;
    assign bus.almost_empty = (cnt <= AE_CNT);
    assign bus.almost_full  = (cnt >= AF_CNT);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a standard-read instance with
// default thresholds and an FWFT DEPTH=4 instance, against queue models.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) if_std ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(4))  if_fw ();

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .bus(if_std)
    );
    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fw (
        .clk(clk), .reset(reset), .bus(if_fw)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_std [$];
    logic [7:0] q_fw [$];
    logic [7:0] m_dout = 8'd0;
    bit m_ovf = 0, m_unf = 0;
    bit f_ovf = 0, f_unf = 0;

    task automatic step_std(input bit r, input bit w, input logic [7:0] d);
        bit rd_ok, wr_ok;
        if_std.r = r; if_std.w = w; if_std.din = d;
        @(posedge clk);
        rd_ok = r && (q_std.size() > 0);
        wr_ok = w && ((q_std.size() < 16) || rd_ok);
        if (rd_ok) m_dout = q_std.pop_front();
        if (wr_ok) q_std.push_back(d);
        m_ovf = w && !wr_ok;
        m_unf = r && !rd_ok;
        #1;
        if_std.r = 1'b0; if_std.w = 1'b0;
    endtask

    task automatic step_fw(input bit r, input bit w, input logic [7:0] d);
        bit rd_ok, wr_ok;
        if_fw.r = r; if_fw.w = w; if_fw.din = d;
        @(posedge clk);
        rd_ok = r && (q_fw.size() > 0);
        wr_ok = w && ((q_fw.size() < 4) || rd_ok);
        if (rd_ok) void'(q_fw.pop_front());
        if (wr_ok) q_fw.push_back(d);
        f_ovf = w && !wr_ok;
        f_unf = r && !rd_ok;
        #1;
        if_fw.r = 1'b0; if_fw.w = 1'b0;
    endtask

    task automatic test_reset();
        if_std.r = 0; if_std.w = 0; if_std.din = 0;
        if_fw.r = 0;  if_fw.w = 0;  if_fw.din = 0;
        reset = 1'b0;
        #100;
        n_tests++;
        if (if_std.count !== 5'd0 || if_std.is_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cnt: count=%0d empty=%b want 0/1",
                     if_std.count, if_std.is_empty);
        end
        n_tests++;
        if (if_std.is_full !== 1'b0 || if_std.almost_full !== 1'b0 ||
            if_std.almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: full=%b af=%b ae=%b want 0/0/1",
                     if_std.is_full, if_std.almost_full, if_std.almost_empty);
        end
        n_tests++;
        if (if_std.overflow !== 1'b0 || if_std.underflow !== 1'b0 ||
            if_std.dout !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_out: ovf=%b unf=%b dout=%0d want 0/0/0",
                     if_std.overflow, if_std.underflow, if_std.dout);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [7:0] v [4];
        v = '{8'd26, 8'd33, 8'd45, 8'd112};
        for (int i = 0; i < 4; i++) begin
            step_std(0, 1, v[i]);
            if (i == 2) begin
                n_tests++;
                if (if_std.count !== 5'd3 || if_std.almost_empty !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_3rd: count=%0d ae=%b want 3/0",
                             if_std.count, if_std.almost_empty);
                end
            end
        end
        n_tests++;
        if (if_std.count !== 5'd4) begin
            n_fail++;
            $display("FAIL fill_count: got %0d want 4", if_std.count);
        end
        for (int i = 0; i < 4; i++) begin
            step_std(1, 0, 0);
            n_tests++;
            if (if_std.dout !== v[i]) begin
                n_fail++;
                $display("FAIL drain_dout[%0d]: got %0d want %0d",
                         i, if_std.dout, v[i]);
            end
        end
        n_tests++;
        if (if_std.is_empty !== 1'b1 || if_std.count !== 5'd0) begin
            n_fail++;
            $display("FAIL drain_end: empty=%b count=%0d want 1/0",
                     if_std.is_empty, if_std.count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            step_std(0, 1, 8'(i));
            n_tests++;
            if (if_std.almost_full !== ((i + 1) >= 14) ||
                if_std.is_full !== ((i + 1) == 16)) begin
                n_fail++;
                $display("FAIL full_flags@%0d: af=%b full=%b want %b/%b",
                         i + 1, if_std.almost_full, if_std.is_full,
                         (i + 1) >= 14, (i + 1) == 16);
            end
        end
        step_std(0, 1, 8'd233);
        n_tests++;
        if (if_std.overflow !== 1'b1 || if_std.count !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b count=%0d want 1/16",
                     if_std.overflow, if_std.count);
        end
        step_std(0, 0, 0);
        n_tests++;
        if (if_std.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_pulse: ovf=%b want 0", if_std.overflow);
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            step_std(1, 1, 8'(100 + i));
            n_tests++;
            if (if_std.count !== 5'd16 || if_std.overflow !== 1'b0 ||
                if_std.dout !== 8'(i)) begin
                n_fail++;
                $display("FAIL rw_full[%0d]: count=%0d ovf=%b dout=%0d want 16/0/%0d",
                         i, if_std.count, if_std.overflow, if_std.dout, i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step_std(1, 0, 0);
            exp = (i < 12) ? 8'(i + 4) : 8'(100 + i - 12);
            n_tests++;
            if (if_std.dout !== exp) begin
                n_fail++;
                $display("FAIL rw_full_order[%0d]: got %0d want %0d",
                         i, if_std.dout, exp);
            end
        end
    endtask

    task automatic test_simul_empty();
        step_std(1, 1, 8'd233);
        n_tests++;
        if (if_std.underflow !== 1'b1 || if_std.count !== 5'd1 ||
            if_std.dout !== 8'd103) begin
            n_fail++;
            $display("FAIL rw_empty: unf=%b count=%0d dout=%0d want 1/1/103",
                     if_std.underflow, if_std.count, if_std.dout);
        end
        step_std(1, 0, 0);
        n_tests++;
        if (if_std.dout !== 8'd233 || if_std.underflow !== 1'b0 ||
            if_std.is_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_empty_read: dout=%0d unf=%b empty=%b want 233/0/1",
                     if_std.dout, if_std.underflow, if_std.is_empty);
        end
    endtask

    task automatic test_empty_read();
        for (int i = 0; i < 3; i++) begin
            step_std(1, 0, 0);
            n_tests++;
            if (if_std.underflow !== 1'b1 || if_std.dout !== 8'd233 ||
                if_std.count !== 5'd0) begin
                n_fail++;
                $display("FAIL empty_read[%0d]: unf=%b dout=%0d count=%0d want 1/233/0",
                         i, if_std.underflow, if_std.dout, if_std.count);
            end
        end
        step_std(0, 0, 0);
        n_tests++;
        if (if_std.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_read_end: unf=%b want 0", if_std.underflow);
        end
    endtask

    task automatic test_random_std();
        bit r, w;
        int sz;
        for (int c = 0; c < 400; c++) begin
            w = $urandom_range(0, 99) < (((c / 50) % 2) ? 80 : 25);
            r = $urandom_range(0, 99) < (((c / 50) % 2) ? 25 : 80);
            step_std(r, w, 8'($urandom));
            sz = q_std.size();
            n_tests++;
            if (if_std.count !== 5'(sz) || if_std.dout !== m_dout) begin
                n_fail++;
                $display("FAIL rand_data@%0d: count=%0d dout=%0d want %0d/%0d",
                         c, if_std.count, if_std.dout, sz, m_dout);
            end
            n_tests++;
            if (if_std.is_empty !== (sz == 0) || if_std.is_full !== (sz == 16) ||
                if_std.almost_empty !== (sz <= 2) ||
                if_std.almost_full !== (sz >= 14)) begin
                n_fail++;
                $display("FAIL rand_flags@%0d: e/f/ae/af=%b%b%b%b size=%0d",
                         c, if_std.is_empty, if_std.is_full,
                         if_std.almost_empty, if_std.almost_full, sz);
            end
            n_tests++;
            if (if_std.overflow !== m_ovf || if_std.underflow !== m_unf) begin
                n_fail++;
                $display("FAIL rand_err@%0d: ovf=%b unf=%b want %b/%b",
                         c, if_std.overflow, if_std.underflow, m_ovf, m_unf);
            end
        end
    endtask

    task automatic test_fwft();
        int written = 0;
        int cyc = 0;
        bit r, w;
        step_fw(0, 1, 8'd26);
        n_tests++;
        if (if_fw.dout !== 8'd26 || if_fw.is_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fwft_head: dout=%0d empty=%b want 26/0",
                     if_fw.dout, if_fw.is_empty);
        end
        step_fw(1, 0, 0);
        n_tests++;
        if (if_fw.is_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fwft_pop: empty=%b want 1", if_fw.is_empty);
        end
        while ((written < 10 || q_fw.size() > 0) && cyc < 200) begin
            w = (written < 10) && ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 1) == 1;
            step_fw(r, w, 8'(50 + written));
            if (w && f_ovf == 0) written++;
            cyc++;
            n_tests++;
            if (if_fw.count !== 3'(q_fw.size()) ||
                (q_fw.size() > 0 && if_fw.dout !== q_fw[0])) begin
                n_fail++;
                $display("FAIL fwft_wrap@%0d: count=%0d dout=%0d want %0d/%0d",
                         cyc, if_fw.count, if_fw.dout, q_fw.size(),
                         (q_fw.size() > 0) ? q_fw[0] : 8'd0);
            end
            n_tests++;
            if (if_fw.overflow !== f_ovf || if_fw.underflow !== f_unf) begin
                n_fail++;
                $display("FAIL fwft_err@%0d: ovf=%b unf=%b want %b/%b",
                         cyc, if_fw.overflow, if_fw.underflow, f_ovf, f_unf);
            end
        end
        n_tests++;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL fwft_timeout: cycles=%0d written=%0d", cyc, written);
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (q_std.size() > 0 && guard < 40) begin
            step_std(1, 0, 0);
            guard++;
        end
        for (int i = 0; i < 5; i++) step_std(0, 1, 8'(200 + i));
        n_tests++;
        if (if_std.count !== 5'd5) begin
            n_fail++;
            $display("FAIL mid_pre: count=%0d want 5", if_std.count);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (if_std.count !== 5'd0 || if_std.is_empty !== 1'b1 ||
            if_std.is_full !== 1'b0 || if_std.almost_empty !== 1'b1 ||
            if_std.almost_full !== 1'b0 || if_std.dout !== 8'd0 ||
            if_std.overflow !== 1'b0 || if_std.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d e/f/ae/af=%b%b%b%b dout=%0d",
                     if_std.count, if_std.is_empty, if_std.is_full,
                     if_std.almost_empty, if_std.almost_full, if_std.dout);
        end
        #1 reset = 1'b1;
        q_std.delete(); q_fw.delete();
        m_dout = 0; m_ovf = 0; m_unf = 0; f_ovf = 0; f_unf = 0;
        step_std(0, 1, 8'd77);
        n_tests++;
        if (if_std.count !== 5'd1) begin
            n_fail++;
            $display("FAIL mid_post_cnt: count=%0d want 1", if_std.count);
        end
        step_std(1, 0, 0);
        n_tests++;
        if (if_std.dout !== 8'd77 || if_std.is_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_post_read: dout=%0d empty=%b want 77/1",
                     if_std.dout, if_std.is_empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full();
        test_simul_full();
        test_simul_empty();
        test_empty_read();
        test_random_std();
        test_fwft();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
